// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, imem read, branch/jump redirect,
// hazard stall, issued-instruction count and halt-word drain.
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [6:0]  total,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [6:0]  r_total;
    logic [6:0]  w_total_nxt;
    logic [7:0]  r_drain;
    logic [7:0]  w_drain_nxt;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_is_halt;
    logic        w_issue;

    // branch_taken belongs to the older instruction, so it wins over jump
    assign w_redirect = branch_taken | jump;
    assign w_target   = branch_taken ? branch_target : jump_target;
    assign w_is_halt  = (imem_data == HALT_WORD);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_total_nxt = r_total;
        w_drain_nxt = r_drain;
        w_issue     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_is_halt) begin
                    w_drain_nxt = 8'(DRAIN_CYCLES - 1);
                    w_state_nxt = (DRAIN_CYCLES <= 1) ? S_HALTED : S_DRAIN;
                end else begin
                    w_issue  = 1'b1;
                    w_pc_nxt = r_pc + 32'd4;
                    if (r_total != 7'd127)
                        w_total_nxt = r_total + 7'd1;
                end
            end
            S_DRAIN: begin
                // A redirect here comes from an older instruction: the halt was wrong-path
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_drain_nxt = '0;
                    w_state_nxt = S_RUN;
                end else if (r_drain <= 8'd1) begin
                    w_drain_nxt = '0;
                    w_state_nxt = S_HALTED;
                end else begin
                    w_drain_nxt = r_drain - 8'd1;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_total <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_total <= w_total_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc + 32'd4;
    assign instr     = w_issue ? imem_data : '0;
    assign total     = r_total;
    assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model pushes expected
// outputs per driven cycle; they are popped and compared against the DUT.
module tb_if_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  total;
    logic        halted;

    logic [31:0] mem [64];

    int n_tests;
    int n_fail;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  total;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_pc;
    int          m_total;
    int          m_state;   // 0 run, 1 drain, 2 halted
    int          m_age;     // cycles spent draining so far

    if_stage #(
        .RESET_PC    (32'h0000_0000),
        .HALT_WORD   (HALT),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .pc           (pc),
        .instr        (instr),
        .total        (total),
        .halted       (halted)
    );

    assign imem_data = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_total = 0;
        m_state = 0;
        m_age   = 0;
    endtask

    // One clock cycle: drive inputs, predict outputs, compare, advance model and clock.
    task automatic cycle(input logic r, input logic st, input logic bt, input logic [31:0] bt_tgt,
                         input logic jp, input logic [31:0] jp_tgt);
        exp_t        e;
        exp_t        got_e;
        logic [31:0] word;
        logic        redir;
        logic [31:0] tgt;
        rst           = r;
        stall         = st;
        branch_taken  = bt;
        branch_target = bt_tgt;
        jump          = jp;
        jump_target   = jp_tgt;
        #1;
        word     = mem[m_pc[7:2]];
        redir    = bt | jp;
        tgt      = bt ? bt_tgt : jp_tgt;
        e.addr   = m_pc;
        e.pc     = m_pc + 32'd4;
        e.total  = 7'(m_total);
        e.halted = (m_state == 2);
        e.instr  = (m_state == 0 && !redir && !st && word != HALT) ? word : 32'h0;
        sb_q.push_back(e);

        got_e = sb_q.pop_front();
        chk("imem_addr", imem_addr, got_e.addr);
        chk("pc", pc, got_e.pc);
        chk("instr", instr, got_e.instr);
        chk("total", {25'h0, total}, {25'h0, got_e.total});
        chk("halted", {31'h0, halted}, {31'h0, got_e.halted});

        if (r) begin
            model_reset();
        end else if (m_state == 0) begin
            if (redir) m_pc = tgt;
            else if (st) m_pc = m_pc;
            else if (word == HALT) begin
                m_state = 1;
                m_age   = 1;
            end else begin
                m_pc    = m_pc + 32'd4;
                m_total = (m_total >= 127) ? 127 : m_total + 1;
            end
        end else if (m_state == 1) begin
            if (redir) begin
                m_pc    = tgt;
                m_state = 0;
            end else begin
                m_age++;
                if (m_age == 4) m_state = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 64; i++) mem[i] = {8'hA5, 8'(i), 16'h0013};
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", pc, 32'h4);
        chk("rst_total", {25'h0, total}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_instr", instr, mem[0]);

        // Sequential fetch, then stall twice at 8
        run(2);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_total", {25'h0, total}, 32'd2);
        run(2);
        chk("resume_addr", imem_addr, 32'h10);

        // Simultaneous branch and jump: branch wins
        cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_total", {25'h0, total}, 32'd4);
        run(2);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("jmp_addr", imem_addr, 32'h80);

        // Halt word at 0x10 drains for 4 cycles, then ignores hazards
        mem[4] = HALT;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        run(4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        run(2);
        chk("drain_halted", {31'h0, halted}, 32'h0);
        run(1);
        chk("halted_set", {31'h0, halted}, 32'h1);
        chk("halted_addr", imem_addr, 32'h10);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30);
        chk("halted_hold", imem_addr, 32'h10);
        chk("halted_total", {25'h0, total}, 32'd4);

        // Branch during drain cancels the halt
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        run(5);
        cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        chk("drbr_addr", imem_addr, 32'h20);
        chk("drbr_halted", {31'h0, halted}, 32'h0);
        run(6);
        chk("drbr_run", {31'h0, halted}, 32'h0);
        mem[4] = {8'hA5, 8'd4, 16'h0013};

        // Saturation of total, then reset mid-run
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        run(130);
        chk("sat_total", {25'h0, total}, 32'd127);
        run(3);
        chk("sat_hold", {25'h0, total}, 32'd127);
        cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        chk("rst2_total", {25'h0, total}, 32'h0);
        chk("rst2_addr", imem_addr, 32'h0);
        run(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
